aud_i2s_rx: RTL and testbench
=============================

AUD_I2S_RX -- requirements
Module: aud_i2s_rx

Interface
REQ-001 Parameter DATA_W, default 16, meaning: sample width in bits, MSB first, two's complement.
REQ-002 Parameter SYNC_STAGES, default 2, meaning: flip-flop depth of the input synchronizers, legal range 2..3.
REQ-003 Port i_clk  input  1  meaning: system clock (12 MHz codec master clock domain), at least 4x BCLK frequency.
REQ-004 Port i_rst_n  input  1  meaning: reset; one clock; reset is asynchronous and active-low.
REQ-005 Port i_en  input  1  meaning: receive enable; low aborts and idles the deserializer.
REQ-006 Port i_aud_bclk  input  1  meaning: codec bit clock, asynchronous to i_clk.
REQ-007 Port i_aud_adclrck  input  1  meaning: codec ADC word clock; low selects left, high selects right.
REQ-008 Port i_aud_adcdat  input  1  meaning: codec ADC serial data.
REQ-009 Port o_left  output  DATA_W  meaning: left sample of the held pair.
REQ-010 Port o_right  output  DATA_W  meaning: right sample of the held pair.
REQ-011 Port o_valid  output  1  meaning: the held pair is valid.
REQ-012 Port i_ready  input  1  meaning: the consumer accepts the pair when o_valid and i_ready are both high.
REQ-013 Port o_overrun  output  1  meaning: one-cycle pulse when a completed pair is dropped.

Function
REQ-014 bclk, adclrck and adcdat SHALL each pass through a SYNC_STAGES synchronizer; all logic uses only the synchronized copies.
REQ-015 bclk_rise SHALL be a one-cycle pulse when synchronized bclk goes 0->1; sampling of lrck and dat occurs only on bclk_rise.
REQ-016 FSM states SHALL be IDLE, SKIP, SHIFT, PAD.
  - IDLE: waits for an lrck change at bclk_rise while i_en=1.
  - On that change the FSM goes to SKIP and latches the channel from the new lrck level.
REQ-017 SKIP SHALL consume exactly one bclk_rise (I2S one-bit delay), then go to SHIFT with the bit counter at 0.
REQ-018 SHIFT SHALL shift adcdat into the channel register on each bclk_rise; after DATA_W bits it SHALL store the word and go to PAD.
REQ-019 PAD SHALL ignore data until an lrck change at bclk_rise, then go to SKIP with the new channel; an lrck change in SHIFT SHALL discard the partial word and go to SKIP.
REQ-020 A pair SHALL complete when the right word is stored after a left word stored in the same frame; a right word without a preceding left word SHALL be discarded.
REQ-021 Pair completion SHALL load o_left and o_right and assert o_valid on the next i_clk edge.
  - If o_valid=1 and i_ready=0 in the completion cycle, the new pair is dropped, held data is unchanged, and o_overrun pulses for one cycle.
REQ-022 Simultaneous completion with o_valid=1 and i_ready=1 SHALL load the new pair and keep o_valid=1 with no overrun.
REQ-023 A handshake (o_valid and i_ready) without completion SHALL clear o_valid on the next edge; o_left and o_right hold their values.
REQ-024 i_en=0 SHALL force IDLE on the next edge and discard any partial left or right word.
  - The held pair and o_valid are unaffected.
REQ-025 Latency from the bclk rising edge carrying the right LSB to o_valid SHALL be at most SYNC_STAGES+3 i_clk cycles.

Reset
REQ-026 Asynchronous i_rst_n low SHALL clear synchronizers, FSM (IDLE), counters, o_left=0, o_right=0, o_valid=0 and o_overrun=0, including mid-frame.
REQ-027 After i_rst_n rises, no pair SHALL be produced before a full left-then-right frame is received.

Configuration
REQ-028 Macro AUD_I2S_RX_OVR_CNT_EN SHALL control an overrun counter.
  - Defined: adds output o_ovr_cnt [15:0], counts o_overrun pulses, saturates at 16'hFFFF, and resets to 0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

Verification
REQ-029 i_en=1, i_ready=1, frame left=16'h8001, right=16'h7FFE -> one o_valid cycle with o_left=16'h8001 and o_right=16'h7FFE.
REQ-030 i_ready=0, two frames (16'h1234/16'h5678, then 16'hAAAA/16'h5555) -> outputs hold 16'h1234/16'h5678, o_overrun pulses once, o_ovr_cnt=1 with the macro.
REQ-031 i_ready asserted exactly in the completion cycle of the second frame (16'h0F0F/16'hF0F0) -> o_valid stays 1, outputs become 16'h0F0F/16'hF0F0, no o_overrun.
REQ-032 i_en dropped after 8 left bits, re-enabled before the next frame (16'h00FF/16'hFF00) -> the only pair output is 16'h00FF/16'hFF00.
REQ-033 i_rst_n pulsed low mid-right-word -> all outputs 0 immediately; the next full frame 16'h0001/16'h0002 is output correctly.
REQ-034 Right-channel-first start (enable while lrck high) -> the first orphan right word is discarded; the next left/right pair is output.

Source files
------------

// File: rtl/aud_i2s_rx.sv
// I2S ADC receiver: synchronizes the codec bit/word clocks and data, deserializes left/right words
// and presents them as a held pair with a valid/ready handshake. Define AUD_I2S_RX_OVR_CNT_EN for o_ovr_cnt.
module aud_i2s_rx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_aud_bclk,
  input  logic              i_aud_adclrck,
  input  logic              i_aud_adcdat,
  output logic [DATA_W-1:0] o_left,
  output logic [DATA_W-1:0] o_right,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overrun
`ifdef AUD_I2S_RX_OVR_CNT_EN
  ,
  output logic [15:0]       o_ovr_cnt
`endif
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, PAD} state_t;

  // Synchronizers: bit 0 = bclk, bit 1 = lrck, bit 2 = data
  logic [2:0] pin_vec;
  logic [2:0] sync_vec;
  assign pin_vec = {i_aud_adcdat, i_aud_adclrck, i_aud_bclk};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain_reg;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        chain_reg <= '0;
      end else begin
        chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_vec[gi]};
      end
    end
    assign sync_vec[gi] = chain_reg[SYNC_STAGES-1];
  end

  logic bclk_s;
  logic lrck_s;
  logic dat_s;
  assign bclk_s = sync_vec[0];
  assign lrck_s = sync_vec[1];
  assign dat_s  = sync_vec[2];

  logic bclk_d_reg;
  logic lrck_last_reg;
  logic bclk_rise;
  logic lrck_chg;

  assign bclk_rise = bclk_s & ~bclk_d_reg;
  assign lrck_chg  = bclk_rise & (lrck_s != lrck_last_reg);

  // lrck is tracked even while disabled so re-enabling mid-word never fakes a boundary
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_d_reg    <= 1'b0;
      lrck_last_reg <= 1'b0;
    end else begin
      bclk_d_reg <= bclk_s;
      if (bclk_rise) begin
        lrck_last_reg <= lrck_s;
      end
    end
  end

  state_t              state_reg, state_next;
  logic                chan_reg, chan_next;
  logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic [DATA_W-1:0]   left_word_reg, left_word_next;
  logic                left_have_reg, left_have_next;
  logic [DATA_W-1:0]   pair_right_reg, pair_right_next;
  logic                pair_done_reg, pair_done_next;
  logic [DATA_W-1:0]   word_in;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      chan_reg       <= 1'b0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      left_word_reg  <= '0;
      left_have_reg  <= 1'b0;
      pair_right_reg <= '0;
      pair_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      chan_reg       <= chan_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      left_word_reg  <= left_word_next;
      left_have_reg  <= left_have_next;
      pair_right_reg <= pair_right_next;
      pair_done_reg  <= pair_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    chan_next       = chan_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    left_word_next  = left_word_reg;
    left_have_next  = left_have_reg;
    pair_right_next = pair_right_reg;
    pair_done_next  = 1'b0;
    word_in         = {shift_reg[DATA_W-2:0], dat_s};

    if (!i_en) begin
      state_next     = IDLE;
      left_have_next = 1'b0;
      bit_cnt_next   = '0;
    end else if (lrck_chg) begin
      // Any word boundary restarts reception; a new left channel opens a new frame
      state_next   = SKIP;
      chan_next    = lrck_s;
      bit_cnt_next = '0;
      if (!lrck_s) begin
        left_have_next = 1'b0;
      end
    end else if (bclk_rise) begin
      case (state_reg)
        SKIP: begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
        end
        SHIFT: begin
          shift_next = word_in;
          if (bit_cnt_reg == LAST_BIT) begin
            state_next = PAD;
            if (!chan_reg) begin
              left_word_next = word_in;
              left_have_next = 1'b1;
            end else if (left_have_reg) begin
              pair_right_next = word_in;
              pair_done_next  = 1'b1;
              left_have_next  = 1'b0;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  logic [DATA_W-1:0] left_out_reg;
  logic [DATA_W-1:0] right_out_reg;
  logic              valid_reg;
  logic              overrun_reg;

  // A completing pair wins over a plain handshake; it is dropped only when the held pair is stuck
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      left_out_reg  <= '0;
      right_out_reg <= '0;
      valid_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (pair_done_reg) begin
        if (valid_reg && !i_ready) begin
          overrun_reg <= 1'b1;
        end else begin
          left_out_reg  <= left_word_reg;
          right_out_reg <= pair_right_reg;
          valid_reg     <= 1'b1;
        end
      end else if (valid_reg && i_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign o_left    = left_out_reg;
  assign o_right   = right_out_reg;
  assign o_valid   = valid_reg;
  assign o_overrun = overrun_reg;

`ifdef AUD_I2S_RX_OVR_CNT_EN
  logic [15:0] ovr_cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovr_cnt_reg <= '0;
    end else if (overrun_reg && (ovr_cnt_reg != 16'hFFFF)) begin
      ovr_cnt_reg <= ovr_cnt_reg + 16'd1;
    end
  end

  assign o_ovr_cnt = ovr_cnt_reg;
`endif

endmodule

// File: tb/tb_aud_i2s_rx.sv
// Self-checking bench for aud_i2s_rx: directed frames plus randomized frames/ready, compared each
// cycle against a pair-level handshake model. Honors AUD_I2S_RX_OVR_CNT_EN when defined.
module tb_aud_i2s_rx;
  localparam int W   = 16;
  localparam int S   = 2;
  localparam int LAT = S + 2;  // i_clk edges from bclk pin rise (right LSB) to o_valid

  logic          i_clk;
  logic          i_rst_n;
  logic          i_en;
  logic          i_aud_bclk;
  logic          i_aud_adclrck;
  logic          i_aud_adcdat;
  logic [W-1:0]  o_left;
  logic [W-1:0]  o_right;
  logic          o_valid;
  logic          i_ready;
  logic          o_overrun;
`ifdef AUD_I2S_RX_OVR_CNT_EN
  logic [15:0]   o_ovr_cnt;
`endif

  aud_i2s_rx #(.DATA_W(W), .SYNC_STAGES(S)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (i_en),
    .i_aud_bclk    (i_aud_bclk),
    .i_aud_adclrck (i_aud_adclrck),
    .i_aud_adcdat  (i_aud_adcdat),
    .o_left        (o_left),
    .o_right       (o_right),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_overrun     (o_overrun)
`ifdef AUD_I2S_RX_OVR_CNT_EN
    ,
    .o_ovr_cnt     (o_ovr_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int           at;
    logic [W-1:0] l;
    logic [W-1:0] r;
  } ev_t;
  ev_t sched[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Output-level model: pairs arrive at scheduled edges, then the handshake rules decide
  logic         m_valid = 1'b0;
  logic [W-1:0] m_left  = '0;
  logic [W-1:0] m_right = '0;
  logic         m_ovr   = 1'b0;
  int           m_cnt   = 0;

  initial begin
    ev_t ev;
    forever begin
      @(posedge i_clk or negedge i_rst_n);
      if (!i_rst_n) begin
        m_valid = 1'b0;
        m_left  = '0;
        m_right = '0;
        m_ovr   = 1'b0;
        m_cnt   = 0;
        sched.delete();
      end else begin
        if (m_ovr && m_cnt < 65535) m_cnt = m_cnt + 1;
        m_ovr = 1'b0;
        if (sched.size() > 0 && sched[0].at == cyc + 1) begin
          ev = sched.pop_front();
          if (m_valid && !i_ready) begin
            m_ovr = 1'b1;
          end else begin
            m_left  = ev.l;
            m_right = ev.r;
            m_valid = 1'b1;
          end
        end else if (m_valid && i_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge i_clk);
      chk("o_valid", 32'(o_valid), 32'(m_valid));
      chk("o_left", 32'(o_left), 32'(m_left));
      chk("o_right", 32'(o_right), 32'(m_right));
      chk("o_overrun", 32'(o_overrun), 32'(m_ovr));
`ifdef AUD_I2S_RX_OVR_CNT_EN
      chk("o_ovr_cnt", 32'(o_ovr_cnt), 32'(m_cnt));
`endif
    end
  end

  // Observation of actual outputs, used only as the "actual" side of literal checks
  int           nv   = 0;
  int           novr = 0;
  logic [W-1:0] cap_l = '0;
  logic [W-1:0] cap_r = '0;
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_valid) begin
        nv++;
        cap_l = o_left;
        cap_r = o_right;
      end
      if (o_overrun) novr++;
    end
  end

  // Ready driver: 0 = level, 1 = random, 2 = high only in the cycle a pair completes
  int   ready_mode = 0;
  logic ready_lvl  = 1'b0;
  initial begin
    i_ready = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      case (ready_mode)
        0: i_ready = ready_lvl;
        1: i_ready = 1'($urandom_range(0, 1));
        default: i_ready = (sched.size() > 0 && sched[0].at == cyc + 1);
      endcase
    end
  end

  task automatic send_bit(input logic lr, input logic d, input logic fire,
                          input logic [W-1:0] l, input logic [W-1:0] r);
    ev_t ev;
    @(posedge i_clk);
    #1;
    i_aud_bclk    = 1'b0;
    i_aud_adclrck = lr;
    i_aud_adcdat  = d;
    repeat (4) @(posedge i_clk);
    #1;
    i_aud_bclk = 1'b1;
    if (fire) begin
      ev.at = cyc + LAT;
      ev.l  = l;
      ev.r  = r;
      sched.push_back(ev);
    end
    repeat (3) @(posedge i_clk);
  endtask

  // Slot bit i: 0 = boundary, 1 = delay bit, 2..W+1 = word MSB first, then pad bits
  task automatic send_slot(input logic lr, input logic [W-1:0] w, input int from, input int to,
                           input int pad, input logic fire, input logic [W-1:0] l,
                           input logic [W-1:0] r);
    logic d;
    for (int i = from; i <= to && i < W + 2 + pad; i++) begin
      if (i >= 2 && i <= W + 1) d = w[W+1-i];
      else d = 1'($urandom_range(0, 1));
      send_bit(lr, d, fire && (i == W + 1), l, r);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                            input int padl, input int padr, input logic exp_pair);
    send_slot(1'b0, l, 0, 999, padl, 1'b0, l, r);
    send_slot(1'b1, r, 0, 999, padr, exp_pair, l, r);
  endtask

  task automatic settle();
    repeat (16) @(posedge i_clk);
    #2;
  endtask

  task automatic drain();
    ready_mode = 0;
    ready_lvl  = 1'b1;
    repeat (3) @(posedge i_clk);
    ready_lvl = 1'b0;
    settle();
  endtask

  initial begin
    int nv0;
    int novr0;
    logic [W-1:0] wl;
    logic [W-1:0] wr;
    i_rst_n       = 1'b0;
    i_en          = 1'b0;
    i_aud_bclk    = 1'b0;
    i_aud_adclrck = 1'b0;
    i_aud_adcdat  = 1'b0;
    repeat (4) @(posedge i_clk);
    #2;
    chk("reset_valid", 32'(o_valid), 32'h0);
    chk("reset_left", 32'(o_left), 32'h0);
    chk("reset_overrun", 32'(o_overrun), 32'h0);
    i_rst_n = 1'b1;
    i_en    = 1'b1;

    // Lead-in right slot: orphan word, nothing may come out of it
    send_slot(1'b1, 16'hDEAD, 0, 999, 1, 1'b0, '0, '0);

    // Basic pair with consumer always ready
    ready_lvl = 1'b1;
    nv0 = nv;
    send_frame(16'h8001, 16'h7FFE, 0, 2, 1'b1);
    settle();
    chk("basic_valid_cycles", 32'(nv - nv0), 32'd1);
    chk("basic_left", 32'(cap_l), 32'h8001);
    chk("basic_right", 32'(cap_r), 32'h7FFE);

    // Stalled consumer: second pair dropped with a single overrun pulse
    ready_lvl = 1'b0;
    novr0 = novr;
    send_frame(16'h1234, 16'h5678, 1, 0, 1'b1);
    send_frame(16'hAAAA, 16'h5555, 0, 1, 1'b1);
    settle();
    chk("stall_valid", 32'(o_valid), 32'h1);
    chk("stall_left", 32'(o_left), 32'h1234);
    chk("stall_right", 32'(o_right), 32'h5678);
    chk("stall_overruns", 32'(novr - novr0), 32'd1);
`ifdef AUD_I2S_RX_OVR_CNT_EN
    chk("stall_ovr_cnt", 32'(o_ovr_cnt), 32'd1);
`endif
    drain();
    chk("drained_valid", 32'(o_valid), 32'h0);

    // Ready exactly in the completion cycle: replace held pair, no overrun
    novr0 = novr;
    send_frame(16'h1111, 16'h2222, 0, 0, 1'b1);
    ready_mode = 2;
    send_frame(16'h0F0F, 16'hF0F0, 0, 2, 1'b1);
    settle();
    ready_mode = 0;
    ready_lvl  = 1'b0;
    #20;
    chk("swap_valid", 32'(o_valid), 32'h1);
    chk("swap_left", 32'(o_left), 32'h0F0F);
    chk("swap_right", 32'(o_right), 32'hF0F0);
    chk("swap_overruns", 32'(novr - novr0), 32'd0);
    drain();

    // Enable dropped after 8 left bits
    ready_lvl = 1'b1;
    nv0 = nv;
    send_slot(1'b0, 16'h1357, 0, 9, 0, 1'b0, '0, '0);
    i_en = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    i_en = 1'b1;
    send_slot(1'b0, 16'h1357, 10, 999, 1, 1'b0, '0, '0);
    send_slot(1'b1, 16'h2468, 0, 999, 1, 1'b0, '0, '0);
    send_frame(16'h00FF, 16'hFF00, 0, 1, 1'b1);
    settle();
    chk("en_valid_cycles", 32'(nv - nv0), 32'd1);
    chk("en_left", 32'(cap_l), 32'h00FF);
    chk("en_right", 32'(cap_r), 32'hFF00);

    // Reset in the middle of a right word
    send_slot(1'b0, 16'h4321, 0, 999, 0, 1'b0, '0, '0);
    send_slot(1'b1, 16'h8765, 0, 9, 0, 1'b0, '0, '0);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_left", 32'(o_left), 32'h0);
    chk("rst_mid_right", 32'(o_right), 32'h0);
    chk("rst_mid_valid", 32'(o_valid), 32'h0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    nv0 = nv;
    send_slot(1'b1, 16'h8765, 10, 999, 0, 1'b0, '0, '0);
    send_frame(16'h0001, 16'h0002, 0, 1, 1'b1);
    settle();
    chk("rst_valid_cycles", 32'(nv - nv0), 32'd1);
    chk("rst_left", 32'(cap_l), 32'h0001);
    chk("rst_right", 32'(cap_r), 32'h0002);

    // Enable while lrck is high: orphan right word first
    i_en = 1'b0;
    send_slot(1'b0, 16'h5A5A, 0, 999, 0, 1'b0, '0, '0);
    @(posedge i_clk);
    #1;
    i_aud_adclrck = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    i_en = 1'b1;
    nv0 = nv;
    send_slot(1'b1, 16'hBEEF, 0, 999, 0, 1'b0, '0, '0);
    send_frame(16'hCAFE, 16'h1357, 0, 1, 1'b1);
    settle();
    chk("rfirst_valid_cycles", 32'(nv - nv0), 32'd1);
    chk("rfirst_left", 32'(cap_l), 32'hCAFE);
    chk("rfirst_right", 32'(cap_r), 32'h1357);

    // Random frames with random consumer readiness
    ready_mode = 1;
    for (int k = 0; k < 30; k++) begin
      wl = W'($urandom);
      wr = W'($urandom);
      send_frame(wl, wr, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end
    ready_mode = 0;
    ready_lvl  = 1'b1;
    settle();
    chk("all_pairs_consumed", 32'(sched.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
